// File: rtl/aes_kat_bist.sv
// Known-answer self-test controller for aes_core_gen: walks a vector memory and runs
// an encipher then a decipher pass per vector, accumulating run pass/fail status.
module aes_kat_bist #(
    parameter int NUM_VEC      = 16,
    parameter int KEY_W        = 256,
    parameter int TIMEOUT      = 255,
    parameter int STOP_ON_FAIL = 0,
    localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    localparam int CW = $clog2(NUM_VEC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [1:0]         cfg_mode,
    output logic [AW-1:0]      vec_addr,
    input  logic [KEY_W+255:0] vec_data,
    output logic               core_reset,
    output logic               core_start,
    output logic               core_enc_dec,
    output logic [1:0]         core_mode,
    output logic [KEY_W-1:0]   core_key,
    output logic [127:0]       core_data_in,
    input  logic [127:0]       core_data_out,
    input  logic               core_done,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CW-1:0]      err_count,
    output logic [AW-1:0]      first_fail_idx,
    output logic               timeout_seen
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_CRST   = 3'd3,
        S_CSTART = 3'd4,
        S_WAIT   = 3'd5,
        S_CHECK  = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t            state_r;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     vec_addr_r;
    logic [KEY_W-1:0]  key_r;
    logic [127:0]      ct_r;
    logic [127:0]      pt_r;
    logic [127:0]      result_r;
    logic [127:0]      data_in_r;
    logic              enc_dec_r;
    logic              vec_fail_r;
    logic [TW-1:0]     tmo_r;
    logic              core_rst_r;
    logic              core_start_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [CW-1:0]     err_count_r;
    logic [AW-1:0]     first_fail_r;
    logic              timeout_r;

    logic [127:0]      expect_s;
    logic              fail_s;
    logic [CW-1:0]     err_next_s;
    logic              last_s;
    logic              stop_s;

    // Phase 0 (encipher) is checked against ct, phase 1 (decipher) against pt.
    assign expect_s   = enc_dec_r ? pt_r : ct_r;
    assign fail_s     = vec_fail_r | (result_r != expect_s);
    assign err_next_s = (err_count_r == {CW{1'b1}}) ? err_count_r : err_count_r + CW'(1);
    assign last_s     = (idx_r == IDX_LAST);
    assign stop_s     = last_s | ((STOP_ON_FAIL != 0) & fail_s);

    assign vec_addr       = vec_addr_r;
    assign core_reset     = reset | core_rst_r;
    assign core_start     = core_start_r;
    assign core_enc_dec   = enc_dec_r;
    assign core_mode      = cfg_mode;
    assign core_key       = key_r;
    assign core_data_in   = data_in_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_count_r;
    assign first_fail_idx = first_fail_r;
    assign timeout_seen   = timeout_r;

    // Self-test sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            idx_r        <= {AW{1'b0}};
            vec_addr_r   <= {AW{1'b0}};
            key_r        <= {KEY_W{1'b0}};
            ct_r         <= 128'd0;
            pt_r         <= 128'd0;
            result_r     <= 128'd0;
            data_in_r    <= 128'd0;
            enc_dec_r    <= 1'b0;
            vec_fail_r   <= 1'b0;
            tmo_r        <= {TW{1'b0}};
            core_rst_r   <= 1'b0;
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_count_r  <= {CW{1'b0}};
            first_fail_r <= {AW{1'b0}};
            timeout_r    <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            core_rst_r   <= 1'b0;
            core_start_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (run) begin
                        busy_r       <= 1'b1;
                        pass_r       <= 1'b0;
                        err_count_r  <= {CW{1'b0}};
                        first_fail_r <= {AW{1'b0}};
                        timeout_r    <= 1'b0;
                        idx_r        <= {AW{1'b0}};
                        vec_addr_r   <= {AW{1'b0}};
                        state_r      <= S_FETCH;
                    end
                end
                S_FETCH: state_r <= S_LOAD;
                S_LOAD: begin
                    key_r      <= vec_data[KEY_W+255:256];
                    ct_r       <= vec_data[255:128];
                    pt_r       <= vec_data[127:0];
                    enc_dec_r  <= 1'b0;
                    vec_fail_r <= 1'b0;
                    core_rst_r <= 1'b1;
                    state_r    <= S_CRST;
                end
                S_CRST: begin
                    core_start_r <= 1'b1;
                    data_in_r    <= enc_dec_r ? ct_r : pt_r;
                    state_r      <= S_CSTART;
                end
                S_CSTART: begin
                    tmo_r   <= {TW{1'b0}};
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        result_r <= core_data_out;
                        state_r  <= S_CHECK;
                    end else if (tmo_r == TMO_LAST) begin
                        vec_fail_r <= 1'b1;
                        timeout_r  <= 1'b1;
                        state_r    <= S_CHECK;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                S_CHECK: begin
                    vec_fail_r <= fail_s;
                    if (!enc_dec_r) begin
                        enc_dec_r  <= 1'b1;
                        core_rst_r <= 1'b1;
                        state_r    <= S_CRST;
                    end else begin
                        // A vector that failed either pass is counted once, here.
                        if (fail_s) begin
                            err_count_r <= err_next_s;
                            if (err_count_r == {CW{1'b0}}) begin
                                first_fail_r <= idx_r;
                            end
                        end
                        if (stop_s) begin
                            done_r  <= 1'b1;
                            pass_r  <= ~fail_s & (err_count_r == {CW{1'b0}});
                            state_r <= S_FINISH;
                        end else begin
                            idx_r      <= idx_r + AW'(1);
                            vec_addr_r <= idx_r + AW'(1);
                            state_r    <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_bist.sv
// Directed known-answer bench for aes_kat_bist: three controller instances (plain, stop-on-fail,
// three-vector) each paired with a vector ROM and a fixed-latency core model keyed to the FIPS-197 vector.
module tb_aes_kat_bist;

    localparam int KEY_W = 256;
    localparam int VW    = KEY_W + 256;
    localparam int D     = 14;
    localparam int TMO   = 20;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cfg_mode;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    logic          run_a    [3];
    logic [VW-1:0] mem      [3][4];
    logic          hold_dec [3][4];
    logic          done_a   [3];
    logic          busy_a   [3];
    logic          pass_a   [3];
    logic          tmo_a    [3];
    logic [2:0]    err_a    [3];
    logic [1:0]    ffi_a    [3];
    logic [1:0]    addr_a   [3];
    int            rst_cnt  [3];
    int            start_cnt[3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NV  = (g == 2) ? 3 : 4;
        localparam int SOF = (g == 1) ? 1 : 0;
        localparam int CWG = $clog2(NV + 1);

        logic [1:0]     vec_addr;
        logic [VW-1:0]  vec_data;
        logic           core_reset;
        logic           core_start;
        logic           core_enc_dec;
        logic [1:0]     core_mode;
        logic [KEY_W-1:0] core_key;
        logic [127:0]   core_data_in;
        logic [127:0]   core_data_out = 128'd0;
        logic           core_done = 1'b0;
        logic           busy;
        logic           done;
        logic           pass;
        logic [CWG-1:0] err_count;
        logic [1:0]     first_fail_idx;
        logic           timeout_seen;
        logic           model_busy = 1'b0;
        logic [127:0]   model_res = 128'd0;
        int             model_cnt = 0;
        int             n_rst = 0;
        int             n_start = 0;

        aes_kat_bist #(
            .NUM_VEC(NV), .KEY_W(KEY_W), .TIMEOUT(TMO), .STOP_ON_FAIL(SOF)
        ) u_dut (
            .clk(clk), .reset(reset), .run(run_a[g]), .cfg_mode(cfg_mode),
            .vec_addr(vec_addr), .vec_data(vec_data),
            .core_reset(core_reset), .core_start(core_start), .core_enc_dec(core_enc_dec),
            .core_mode(core_mode), .core_key(core_key), .core_data_in(core_data_in),
            .core_data_out(core_data_out), .core_done(core_done),
            .busy(busy), .done(done), .pass(pass), .err_count(err_count),
            .first_fail_idx(first_fail_idx), .timeout_seen(timeout_seen)
        );

        always_ff @(posedge clk) vec_data <= mem[g][vec_addr];

        // Core model: done D cycles after start; real AES answer only for the FIPS vector.
        always @(posedge clk) begin
            core_done <= 1'b0;
            if (core_reset) begin
                model_busy <= 1'b0;
            end else if (core_start) begin
                model_busy <= !(core_enc_dec && hold_dec[g][vec_addr]);
                model_cnt  <= D - 2;
                if (!core_enc_dec)
                    model_res <= (core_data_in == FIPS_PT && core_key == FIPS_KEY) ? FIPS_CT : ~core_data_in;
                else
                    model_res <= (core_data_in == FIPS_CT && core_key == FIPS_KEY) ? FIPS_PT : ~core_data_in;
            end else if (model_busy) begin
                if (model_cnt == 0) begin
                    core_done     <= 1'b1;
                    core_data_out <= model_res;
                    model_busy    <= 1'b0;
                end else begin
                    model_cnt <= model_cnt - 1;
                end
            end
        end

        always @(posedge clk) begin
            if (core_reset && !reset) n_rst <= n_rst + 1;
            if (core_start) n_start <= n_start + 1;
        end

        assign done_a[g]    = done;
        assign busy_a[g]    = busy;
        assign pass_a[g]    = pass;
        assign tmo_a[g]     = timeout_seen;
        assign err_a[g]     = 3'(err_count);
        assign ffi_a[g]     = first_fail_idx;
        assign addr_a[g]    = vec_addr;
        assign rst_cnt[g]   = n_rst;
        assign start_cnt[g] = n_start;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse run, wait (bounded) for done, return cycles from the run cycle to the done cycle.
    task automatic do_run(input int g, input int poke_cyc, input bit poke_done, output int lat);
        int c0;
        int n;
        @(negedge clk);
        run_a[g] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        run_a[g] = 1'b0;
        check("busy_after_run", 256'(busy_a[g]), 256'(1));
        check("fetch_addr", 256'(addr_a[g]), 256'(0));
        n = 0;
        while (!done_a[g] && n < 2000) begin
            @(negedge clk);
            n++;
            if (poke_cyc != 0) run_a[g] = ((cyc - c0) == poke_cyc);
        end
        check("done_seen", 256'(done_a[g]), 256'(1));
        lat = cyc - c0;
        run_a[g] = poke_done;
        @(negedge clk);
        run_a[g] = 1'b0;
        check("done_pulse", 256'(done_a[g]), 256'(0));
        check("idle_after_finish", 256'(busy_a[g]), 256'(0));
    endtask

    initial begin
        int lat;
        int c0;
        int r0;
        int s0;
        int nd;
        reset    = 1'b1;
        cfg_mode = 2'b10;
        for (int g = 0; g < 3; g++) begin
            run_a[g] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem[g][i]      = {FIPS_KEY, FIPS_CT, FIPS_PT};
                hold_dec[g][i] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        check("rst_core_reset", 256'(g_dut[0].core_reset), 256'(1));
        check("rst_busy", 256'(g_dut[0].busy), 256'(0));
        check("rst_done", 256'(g_dut[0].done), 256'(0));
        check("rst_pass", 256'(g_dut[0].pass), 256'(0));
        check("rst_err", 256'(g_dut[0].err_count), 256'(0));
        check("rst_ffi", 256'(g_dut[0].first_fail_idx), 256'(0));
        check("rst_tmo", 256'(g_dut[0].timeout_seen), 256'(0));
        check("rst_addr", 256'(g_dut[0].vec_addr), 256'(0));
        check("rst_start", 256'(g_dut[0].core_start), 256'(0));
        check("rst_encdec", 256'(g_dut[0].core_enc_dec), 256'(0));
        check("rst_key", 256'(g_dut[0].core_key), 256'(0));
        check("rst_din", 256'(g_dut[0].core_data_in), 256'(0));
        check("rst_mode", 256'(g_dut[0].core_mode), 256'(2));
        reset = 1'b0;
        @(negedge clk);
        check("idle_core_reset", 256'(g_dut[0].core_reset), 256'(0));

        // All vectors good: 4 * (2*14 + 8) + 1 cycles.
        do_run(0, 0, 1'b0, lat);
        check("allpass_lat", 256'(lat), 256'(145));
        check("allpass_pass", 256'(pass_a[0]), 256'(1));
        check("allpass_err", 256'(err_a[0]), 256'(0));
        check("allpass_tmo", 256'(tmo_a[0]), 256'(0));
        check("allpass_addr", 256'(addr_a[0]), 256'(3));

        // Ciphertext bit 0 flipped in vector 2.
        mem[0][2] = {FIPS_KEY, FIPS_CT ^ 128'd1, FIPS_PT};
        do_run(0, 0, 1'b0, lat);
        check("ct_lat", 256'(lat), 256'(145));
        check("ct_pass", 256'(pass_a[0]), 256'(0));
        check("ct_err", 256'(err_a[0]), 256'(1));
        check("ct_ffi", 256'(ffi_a[0]), 256'(2));
        check("ct_tmo", 256'(tmo_a[0]), 256'(0));
        check("ct_addr", 256'(addr_a[0]), 256'(3));

        // Decipher of vector 1 never completes: its WAIT runs 20 cycles instead of 14.
        mem[0][2] = {FIPS_KEY, FIPS_CT, FIPS_PT};
        hold_dec[0][1] = 1'b1;
        do_run(0, 0, 1'b0, lat);
        check("to_lat", 256'(lat), 256'(151));
        check("to_tmo", 256'(tmo_a[0]), 256'(1));
        check("to_err", 256'(err_a[0]), 256'(1));
        check("to_ffi", 256'(ffi_a[0]), 256'(1));
        check("to_pass", 256'(pass_a[0]), 256'(0));

        // Stop on fail, vectors 1 and 3 corrupt: ends after vector 1.
        mem[1][1] = {FIPS_KEY, FIPS_CT ^ 128'd1, FIPS_PT};
        mem[1][3] = {FIPS_KEY, FIPS_CT ^ 128'd1, FIPS_PT};
        do_run(1, 0, 1'b0, lat);
        check("sof_lat", 256'(lat), 256'(73));
        check("sof_err", 256'(err_a[1]), 256'(1));
        check("sof_ffi", 256'(ffi_a[1]), 256'(1));
        check("sof_pass", 256'(pass_a[1]), 256'(0));
        check("sof_addr", 256'(addr_a[1]), 256'(1));

        // Reset during encipher WAIT of vector 2 (vector 1 times out first, so status is non-zero).
        @(negedge clk);
        run_a[0] = 1'b1;
        c0 = cyc;
        @(negedge clk);
        run_a[0] = 1'b0;
        while ((cyc - c0) < 88) @(negedge clk);
        check("pre_rst_busy", 256'(busy_a[0]), 256'(1));
        check("pre_rst_addr", 256'(addr_a[0]), 256'(2));
        check("pre_rst_encdec", 256'(g_dut[0].core_enc_dec), 256'(0));
        check("pre_rst_err", 256'(err_a[0]), 256'(1));
        check("pre_rst_tmo", 256'(tmo_a[0]), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_core_reset", 256'(g_dut[0].core_reset), 256'(1));
        check("abort_busy", 256'(busy_a[0]), 256'(0));
        check("abort_done", 256'(done_a[0]), 256'(0));
        check("abort_err", 256'(err_a[0]), 256'(0));
        check("abort_ffi", 256'(ffi_a[0]), 256'(0));
        check("abort_tmo", 256'(tmo_a[0]), 256'(0));
        check("abort_addr", 256'(addr_a[0]), 256'(0));
        check("abort_start", 256'(g_dut[0].core_start), 256'(0));
        reset = 1'b0;
        nd = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_a[0] || busy_a[0]) nd++;
        end
        check("abort_quiet", 256'(nd), 256'(0));

        // Restart; run pulsed mid-run and again on the done cycle must be ignored.
        hold_dec[0][1] = 1'b0;
        do_run(0, 50, 1'b1, lat);
        check("rerun_lat", 256'(lat), 256'(145));
        check("rerun_pass", 256'(pass_a[0]), 256'(1));
        check("rerun_err", 256'(err_a[0]), 256'(0));
        @(negedge clk);
        check("rerun_idle", 256'(busy_a[0]), 256'(0));

        // Three vectors, all corrupt: two-bit count reaches 3 without wrapping.
        for (int i = 0; i < 3; i++) mem[2][i] = {FIPS_KEY, FIPS_CT ^ 128'd1, FIPS_PT};
        r0 = rst_cnt[2];
        s0 = start_cnt[2];
        do_run(2, 0, 1'b0, lat);
        check("sat_lat", 256'(lat), 256'(109));
        check("sat_err", 256'(err_a[2]), 256'(3));
        check("sat_ffi", 256'(ffi_a[2]), 256'(0));
        check("sat_pass", 256'(pass_a[2]), 256'(0));
        check("sat_core_reset_cycles", 256'(rst_cnt[2] - r0), 256'(6));
        check("sat_core_start_cycles", 256'(start_cnt[2] - s0), 256'(6));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
